// File: rtl/seg7_scan_display_if.sv
// Digit bus from the frequency meter and the multiplexed display drive lines.
// The meter side (master) drives the digits; the scanner (slave) drives the display.
interface seg7_scan_display_if;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic [3:0] d4;
   logic [3:0] d5;
   logic [3:0] d6;
   logic [3:0] d7;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic       frame_tick;

   modport master (
      output d0, d1, d2, d3, d4, d5, d6, d7,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  d0, d1, d2, d3, d4, d5, d6, d7,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed 7-segment scanner: synchronises the meter's BCD bus, latches
// a frame only when it was stable across the last slot, blanks leading zeros.
module seg7_scan_display #(
   parameter int unsigned CLK_HZ         = 50_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned GUARD          = 2,
   parameter int unsigned BLANK_LZ       = 1,
   parameter logic [7:0]  DP_MASK        = 8'h00,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned AN_ACTIVE_LOW  = 1
) (
   input logic                 clk_50MHz,
   input logic                 rst_n,
   seg7_scan_display_if.slave  bus
);

   localparam int unsigned DIV      = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned BUS_W    = 32;
   localparam int unsigned SEG_W    = 7;
   localparam int unsigned AN_W     = 8;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

   localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic             DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;
   localparam logic [AN_W-1:0]  AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 8'hFF : 8'h00;

   // Active-high {g,f,e,d,c,b,a} pattern; non-BCD codes show a dash
   function automatic logic [SEG_W-1:0] decode(input logic [3:0] v);
      logic [SEG_W-1:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [IDX_W-1:0] idx_q,  idx_d;
   logic [BUS_W-1:0] raw_q,  raw_d;
   logic [BUS_W-1:0] raw2_q, raw2_d;
   logic [BUS_W-1:0] snap_q, snap_d;
   logic [BUS_W-1:0] disp_q, disp_d;
   logic [SEG_W-1:0] seg_q,  seg_d;
   logic             dp_q,   dp_d;
   logic [AN_W-1:0]  an_q,   an_d;
   logic             frame_tick_q, frame_tick_d;

   logic             tick;
   logic             frame_end;
   logic [AN_W-1:0]  blank;
   logic             upper_nz;
   logic [3:0]       cur_digit;
   logic             cur_blank;
   logic [SEG_W-1:0] seg_ah;
   logic             dp_ah;
   logic [AN_W-1:0]  an_ah;

   assign tick      = (cnt_q == CNT_MAX);
   assign frame_end = tick && (idx_q == IDX_LAST);

   // Leading-zero mask: digit k blanks when it and every digit above it are zero
   always_comb begin
      blank    = '0;
      upper_nz = 1'b0;
      for (int k = 7; k >= 1; k--) begin
         upper_nz = upper_nz | (disp_q[4*k +: 4] != 4'd0);
         blank[k] = (BLANK_LZ != 0) && !upper_nz;
      end
   end

   // Prescaler, scan index and the capture / stability-filter pipeline
   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d  = tick ? idx_q + IDX_W'(1) : idx_q;
      raw_d  = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
      raw2_d = raw_q;
      snap_d = tick ? raw2_q : snap_q;
      disp_d = disp_q;
      // snap_q was taken at the end of slot 6; matching raw2 now means a quiet slot
      if (frame_end && (snap_q == raw2_q)) begin
         disp_d = snap_q;
      end
   end

   // Output decode from the current slot, registered below
   always_comb begin
      cur_digit = disp_q[{idx_q, 2'b00} +: 4];
      cur_blank = blank[idx_q];
      seg_ah    = cur_blank ? '0 : decode(cur_digit);
      dp_ah     = DP_MASK[idx_q] && !cur_blank;
      an_ah     = '0;
      if ((cnt_q >= CNT_GUARD) && !cur_blank) begin
         an_ah = AN_W'(1) << idx_q;
      end
      seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
      dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_ah  : dp_ah;
      an_d         = (AN_ACTIVE_LOW  != 0) ? ~an_ah  : an_ah;
      frame_tick_d = frame_end;
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         raw_q        <= '0;
         raw2_q       <= '0;
         snap_q       <= '0;
         disp_q       <= '0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         raw_q        <= raw_d;
         raw2_q       <= raw2_d;
         snap_q       <= snap_d;
         disp_q       <= disp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (leading-zero blanking on, no DPs /
// blanking off, DP on digit 3) fed the same digits, DIV=8, GUARD=2, active-low.
module tb_seg7_scan_display;

   logic clk;
   logic rst_n;

   seg7_scan_display_if ifa ();
   seg7_scan_display_if ifb ();

   seg7_scan_display #(
      .CLK_HZ(8), .SCAN_HZ(1), .GUARD(2), .BLANK_LZ(1), .DP_MASK(8'h00),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_a (
      .clk_50MHz(clk), .rst_n(rst_n), .bus(ifa.slave)
   );

   seg7_scan_display #(
      .CLK_HZ(8), .SCAN_HZ(1), .GUARD(2), .BLANK_LZ(0), .DP_MASK(8'h08),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_b (
      .clk_50MHz(clk), .rst_n(rst_n), .bus(ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compares = 0;
   int fails    = 0;

   typedef struct {
      logic [31:0] digits;
      int          idx;
      logic [6:0]  seg_a;
      logic [7:0]  an_a;
      logic        dp_a;
      logic [6:0]  seg_b;
      logic [7:0]  an_b;
      logic        dp_b;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_digits(input logic [31:0] v);
      ifa.d0 = v[3:0];   ifa.d1 = v[7:4];   ifa.d2 = v[11:8];  ifa.d3 = v[15:12];
      ifa.d4 = v[19:16]; ifa.d5 = v[23:20]; ifa.d6 = v[27:24]; ifa.d7 = v[31:28];
      ifb.d0 = v[3:0];   ifb.d1 = v[7:4];   ifb.d2 = v[11:8];  ifb.d3 = v[15:12];
      ifb.d4 = v[19:16]; ifb.d5 = v[23:20]; ifb.d6 = v[27:24]; ifb.d7 = v[31:28];
   endtask

   // Returns on the negedge where frame_tick is high; the next negedge shows slot 0, cnt 0
   task automatic wait_ft();
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ifa.frame_tick === 1'b1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("frame_tick_timeout", 32'd0, 32'd1);
      else       chk("frame_tick_b_aligned", 32'(ifb.frame_tick), 32'd1);
   endtask

   // Release reset on a negedge and check the scan restarts at idx 0, cnt 0 with disp 0
   task automatic release_and_check(input string tag);
      bit seen = 0;
      int n;
      @(negedge clk);
      rst_n = 1'b1;
      for (n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 1) chk({tag, "_an_a_guard"}, 32'(ifa.an), 32'hFF);
         if (n == 3) begin
            chk({tag, "_an_a_slot0"},  32'(ifa.an),  32'hFE);
            chk({tag, "_seg_a_slot0"}, 32'(ifa.seg), 32'h40);
            chk({tag, "_an_b_slot0"},  32'(ifb.an),  32'hFE);
         end
         if (ifa.frame_tick === 1'b1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk({tag, "_first_frame_timeout"}, 32'd0, 32'd1);
      else       chk({tag, "_first_frame_cycles"}, 32'(n), 32'd64);
   endtask

   task automatic check_off(input string tag);
      chk({tag, "_seg_a"}, 32'(ifa.seg), 32'h7F);
      chk({tag, "_dp_a"},  32'(ifa.dp),  32'h1);
      chk({tag, "_an_a"},  32'(ifa.an),  32'hFF);
      chk({tag, "_ft_a"},  32'(ifa.frame_tick), 32'h0);
      chk({tag, "_seg_b"}, 32'(ifb.seg), 32'h7F);
      chk({tag, "_an_b"},  32'(ifb.an),  32'hFF);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cur;
      logic [6:0]  v0;
      int          j;
      int          per;
      bit          seen;

      //             digits        idx seg_a  an_a   dp_a  seg_b  an_b   dp_b
      vecs[0]  = '{32'h00012345, 0, 7'h12, 8'hFE, 1'b1, 7'h12, 8'hFE, 1'b1};
      vecs[1]  = '{32'h00012345, 3, 7'h24, 8'hF7, 1'b1, 7'h24, 8'hF7, 1'b0};
      vecs[2]  = '{32'h00012345, 4, 7'h79, 8'hEF, 1'b1, 7'h79, 8'hEF, 1'b1};
      vecs[3]  = '{32'h00012345, 5, 7'h7F, 8'hFF, 1'b1, 7'h40, 8'hDF, 1'b1};
      vecs[4]  = '{32'h00012345, 7, 7'h7F, 8'hFF, 1'b1, 7'h40, 8'h7F, 1'b1};
      vecs[5]  = '{32'h00000000, 0, 7'h40, 8'hFE, 1'b1, 7'h40, 8'hFE, 1'b1};
      vecs[6]  = '{32'h00000000, 1, 7'h7F, 8'hFF, 1'b1, 7'h40, 8'hFD, 1'b1};
      vecs[7]  = '{32'h00000000, 3, 7'h7F, 8'hFF, 1'b1, 7'h40, 8'hF7, 1'b0};
      vecs[8]  = '{32'h1111C111, 3, 7'h3F, 8'hF7, 1'b1, 7'h3F, 8'hF7, 1'b0};
      vecs[9]  = '{32'h1111C111, 0, 7'h79, 8'hFE, 1'b1, 7'h79, 8'hFE, 1'b1};
      vecs[10] = '{32'h1111C111, 7, 7'h79, 8'h7F, 1'b1, 7'h79, 8'h7F, 1'b1};
      vecs[11] = '{32'h00000090, 1, 7'h10, 8'hFD, 1'b1, 7'h10, 8'hFD, 1'b1};
      vecs[12] = '{32'h00000090, 2, 7'h7F, 8'hFF, 1'b1, 7'h40, 8'hFB, 1'b1};
      vecs[13] = '{32'h87654321, 6, 7'h78, 8'hBF, 1'b1, 7'h78, 8'hBF, 1'b1};
      vecs[14] = '{32'h87654321, 7, 7'h00, 8'h7F, 1'b1, 7'h00, 8'h7F, 1'b1};
      vecs[15] = '{32'h000F0000, 4, 7'h3F, 8'hEF, 1'b1, 7'h3F, 8'hEF, 1'b1};
      vecs[16] = '{32'h000F0000, 0, 7'h40, 8'hFE, 1'b1, 7'h40, 8'hFE, 1'b1};

      rst_n = 1'b0;
      cur   = 32'h00012345;
      set_digits(cur);
      repeat (4) @(negedge clk);
      check_off("reset");
      release_and_check("boot");

      // Frame period
      seen = 0;
      for (per = 1; per <= 200; per++) begin
         @(negedge clk);
         if (ifa.frame_tick === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("frame_period", seen ? 32'(per) : 32'd0, 32'd64);

      // Table: settle the digits for two frames, then walk to the target slot
      for (int v = 0; v < NVEC; v++) begin
         if (vecs[v].digits != cur) begin
            cur = vecs[v].digits;
            set_digits(cur);
            wait_ft();
         end
         wait_ft();
         repeat (vecs[v].idx * 8) @(negedge clk);
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_seg_a", v), 32'(ifa.seg), 32'(vecs[v].seg_a));
            chk($sformatf("v%0d_dp_a", v),  32'(ifa.dp),  32'(vecs[v].dp_a));
            chk($sformatf("v%0d_an_a", v),  32'(ifa.an),  (c >= 2) ? 32'(vecs[v].an_a) : 32'hFF);
            chk($sformatf("v%0d_seg_b", v), 32'(ifb.seg), 32'(vecs[v].seg_b));
            chk($sformatf("v%0d_dp_b", v),  32'(ifb.dp),  32'(vecs[v].dp_b));
            chk($sformatf("v%0d_an_b", v),  32'(ifb.an),  (c >= 2) ? 32'(vecs[v].an_b) : 32'hFF);
         end
      end

      // Unstable bus: flipping d0 once per slot makes snap and raw2 disagree at every frame end
      cur = 32'h00000001;
      set_digits(cur);
      wait_ft();
      wait_ft();
      j = 0;
      for (int k = 0; k < 3 * 64; k++) begin
         @(negedge clk);
         if (ifa.frame_tick === 1'b1) j = 0;
         else                          j++;
         if ((j >= 3) && (j <= 8)) chk("toggle_hold_seg_a", 32'(ifa.seg), 32'h79);
         set_digits(((k / 8) % 2 == 1) ? 32'h00000002 : 32'h00000001);
      end
      cur = 32'h00000002;
      set_digits(cur);
      wait_ft();
      @(negedge clk);
      v0 = ifa.seg;
      chk("settle_seg_a_valid", 32'((v0 == 7'h79) || (v0 == 7'h24)), 32'd1);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         chk("settle_no_tear", 32'(ifa.seg), 32'(v0));
      end
      wait_ft();
      repeat (3) @(negedge clk);
      chk("settle_seg_a_new", 32'(ifa.seg), 32'h24);
      chk("settle_an_a_new",  32'(ifa.an),  32'hFE);

      // Asynchronous reset in the middle of slot 4
      wait_ft();
      repeat (36) @(negedge clk);
      chk("pre_rst_an_b_slot4",  32'(ifb.an),  32'hEF);
      chk("pre_rst_seg_b_slot4", 32'(ifb.seg), 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      check_off("midreset");
      repeat (2) @(negedge clk);
      check_off("midreset_hold");
      release_and_check("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
